// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    FULL
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/if_fetch_unit.sv
// IF stage: owns the PC, fetches over a valid/ready imem port and
// holds one instruction for IF/ID; drops wrong-path responses.
module if_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_f,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] instr_f,
  output logic [31:0] pc_f,
  output logic [31:0] pc_plus4_f,
  output logic        valid_f
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  buf_instr_q;
  logic [31:0]  buf_pc_q;
  logic         valid_q;
  logic         kill_q;
  logic         req_fire;

  always_comb begin
    imem_req_valid = 1'b0;
    unique case (state_q)
      REQ:     imem_req_valid = ~redirect;
      FULL:    imem_req_valid = ~stall_f & ~redirect;
      default: imem_req_valid = 1'b0;
    endcase
  end

  assign req_fire = imem_req_valid & imem_req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      buf_instr_q <= NOP_INSTR;
      buf_pc_q    <= 32'h0;
      valid_q     <= 1'b0;
      kill_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: state_q <= REQ;
        REQ: begin
          if (redirect) begin
            pc_q    <= redirect_pc;
            valid_q <= 1'b0;
          end else if (imem_req_ready) begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (redirect) begin
            pc_q    <= redirect_pc;
            valid_q <= 1'b0;
            if (imem_rsp_valid) begin
              kill_q  <= 1'b0;
              state_q <= REQ;
            end else begin
              kill_q  <= 1'b1;
            end
          end else if (imem_rsp_valid) begin
            if (kill_q) begin
              kill_q  <= 1'b0;
              state_q <= REQ;
            end else begin
              buf_instr_q <= imem_rsp_data;
              buf_pc_q    <= pc_q;
              valid_q     <= 1'b1;
              pc_q        <= pc_q + 32'd4;
              state_q     <= FULL;
            end
          end
        end
        FULL: begin
          if (redirect) begin
            pc_q    <= redirect_pc;
            valid_q <= 1'b0;
            state_q <= REQ;
          end else if (!stall_f) begin
            valid_q <= 1'b0;
            state_q <= req_fire ? WAIT : REQ;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign imem_req_addr = pc_q;
  assign instr_f       = valid_q ? buf_instr_q : NOP_INSTR;
  assign pc_f          = buf_pc_q;
  assign pc_plus4_f    = buf_pc_q + 32'd4;
  assign valid_f       = valid_q;

  // Memory may only answer a request we are waiting on.
  rsp_in_wait_a: assert property (
    @(posedge clk) disable iff (rst)
    imem_rsp_valid |-> state_q == WAIT
  );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a small imem responder
// returning addr ^ 32'hA5A5_0000 after a programmable delay.
module tb_if_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_f = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic [31:0] instr_f;
  logic [31:0] pc_f;
  logic [31:0] pc_plus4_f;
  logic        valid_f;

  int checks = 0;
  int errors = 0;

  logic        pend = 1'b0;
  logic [31:0] pend_addr = 32'h0;
  int          pend_cnt = 0;
  int          rsp_delay = 1;

  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall_f        (stall_f),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_f        (instr_f),
    .pc_f           (pc_f),
    .pc_plus4_f     (pc_plus4_f),
    .valid_f        (valid_f)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // One clock: sample the handshake at negedge, then update the responder.
  task automatic tick();
    logic        acc;
    logic [31:0] a;
    @(negedge clk);
    acc = imem_req_valid & imem_req_ready;
    a   = imem_req_addr;
    @(posedge clk);
    #1;
    imem_rsp_valid = 1'b0;
    if (acc === 1'b1) begin
      pend      = 1'b1;
      pend_addr = a;
      pend_cnt  = rsp_delay;
    end
    if (pend) begin
      if (pend_cnt <= 1) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = pend_addr ^ KEY;
        pend           = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
  endtask

  task automatic out(input string tag, input logic [31:0] pc);
    logic [31:0] p4;
    p4 = pc + 32'd4;
    chk({tag, ".valid"}, {31'b0, valid_f}, 32'd1);
    chk({tag, ".pc"}, pc_f, pc);
    chk({tag, ".pc4"}, pc_plus4_f, p4);
    chk({tag, ".instr"}, instr_f, pc ^ KEY);
  endtask

  initial begin
    tick();
    chk("rst.valid", {31'b0, valid_f}, 32'd0);
    chk("rst.instr", instr_f, 32'h0000_0013);
    chk("rst.pc", pc_f, 32'h0);
    chk("rst.pc4", pc_plus4_f, 32'h4);
    chk("rst.reqv", {31'b0, imem_req_valid}, 32'd0);
    chk("rst.addr", imem_req_addr, 32'h100);
    rst = 1'b0;

    tick();
    chk("c1.reqv", {31'b0, imem_req_valid}, 32'd1);
    chk("c1.addr", imem_req_addr, 32'h100);
    chk("c1.valid", {31'b0, valid_f}, 32'd0);
    tick();
    chk("c2.reqv", {31'b0, imem_req_valid}, 32'd0);
    chk("c2.valid", {31'b0, valid_f}, 32'd0);
    tick();
    out("c3", 32'h100);
    chk("c3.addr", imem_req_addr, 32'h104);
    tick();
    chk("c4.valid", {31'b0, valid_f}, 32'd0);
    tick();
    out("c5", 32'h104);
    tick();
    tick();
    out("c7", 32'h108);

    stall_f = 1'b1;
    #1;
    chk("st.reqv", {31'b0, imem_req_valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      out("st.hold", 32'h108);
      chk("st.reqv_h", {31'b0, imem_req_valid}, 32'd0);
    end
    stall_f = 1'b0;
    #1;
    chk("st.rel_v", {31'b0, imem_req_valid}, 32'd1);
    chk("st.rel_a", imem_req_addr, 32'h10C);
    tick();
    tick();
    out("st.next", 32'h10C);

    rsp_delay = 2;
    tick();
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    tick();
    redirect = 1'b0;
    #1;
    chk("rk.valid", {31'b0, valid_f}, 32'd0);
    chk("rk.reqv", {31'b0, imem_req_valid}, 32'd0);
    tick();
    chk("rk.reqv2", {31'b0, imem_req_valid}, 32'd1);
    chk("rk.addr", imem_req_addr, 32'h200);
    rsp_delay = 1;
    tick();
    tick();
    out("rk.out", 32'h200);

    tick();
    redirect    = 1'b1;
    redirect_pc = 32'h300;
    tick();
    redirect = 1'b0;
    #1;
    chk("rr.valid", {31'b0, valid_f}, 32'd0);
    chk("rr.reqv", {31'b0, imem_req_valid}, 32'd1);
    chk("rr.addr", imem_req_addr, 32'h300);

    imem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("nr.addr", imem_req_addr, 32'h300);
      chk("nr.reqv", {31'b0, imem_req_valid}, 32'd1);
      chk("nr.valid", {31'b0, valid_f}, 32'd0);
    end
    redirect    = 1'b1;
    redirect_pc = 32'h400;
    #1;
    chk("nr.wdraw", {31'b0, imem_req_valid}, 32'd0);
    tick();
    redirect = 1'b0;
    #1;
    chk("nr.reqv2", {31'b0, imem_req_valid}, 32'd1);
    chk("nr.addr2", imem_req_addr, 32'h400);
    imem_req_ready = 1'b1;
    tick();
    tick();
    out("nr.out", 32'h400);

    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    #1;
    chk("wr.valid", {31'b0, valid_f}, 32'd0);
    chk("wr.addr", imem_req_addr, 32'hFFFF_FFFC);
    tick();
    tick();
    out("wr.out", 32'hFFFF_FFFC);
    chk("wr.next", imem_req_addr, 32'h0);

    stall_f = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    chk("ar.valid", {31'b0, valid_f}, 32'd0);
    chk("ar.instr", instr_f, 32'h0000_0013);
    chk("ar.pc4", pc_plus4_f, 32'h4);
    chk("ar.reqv", {31'b0, imem_req_valid}, 32'd0);
    chk("ar.addr", imem_req_addr, 32'h100);
    stall_f = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("ar.reqv2", {31'b0, imem_req_valid}, 32'd1);
    chk("ar.addr2", imem_req_addr, 32'h100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage that owns the program counter, issues requests to instruction memory over a valid/ready interface, and presents {instruction, PC, PC+4} to the IF/ID pipeline register. It honours the hazard unit's IF stall and EX-stage redirects (taken branch/jump). Wrong-path responses already in flight are discarded.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- NOP_INSTR, 32'h0000_0013, instruction driven when no valid fetch is held (addi x0,x0,0)

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- stall_f  in  1  IF/ID not accepting this cycle (IF/ID en = ~stall_f)
- redirect  in  1  taken branch/jump resolved in EX
- redirect_pc  in  32  redirect target
- imem_req_valid  out  1  fetch request
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  fetch address
- imem_rsp_valid  in  1  response data valid
- imem_rsp_data  in  32  fetched instruction
- instr_f  out  32  instruction to IF/ID (NOP_INSTR when valid_f=0)
- pc_f  out  32  PC of instr_f
- pc_plus4_f  out  32  pc_f + 4
- valid_f  out  1  instr_f is a real fetched instruction

## Operation
- State: pc_q (next fetch address), output buffer {instr, pc, valid}, kill flag, FSM IDLE/REQ/WAIT/FULL.
- IDLE: reset state. Moves to REQ on the first edge after rst deasserts. No request is issued.
- REQ: imem_req_valid = ~redirect, imem_req_addr = pc_q. If valid & ready: go to WAIT.
- WAIT: on imem_rsp_valid with kill=0: buffer <= {rsp_data, pc_q}, valid <= 1, pc_q <= pc_q + 4 (mod 2^32), go to FULL. With kill=1: drop the response, clear kill, go to REQ.
- FULL: valid_f=1, and the outputs hold stable. imem_req_valid = ~stall_f & ~redirect, addr = pc_q. On an edge with ~stall_f the buffer is consumed. Then: if a request was accepted, go to WAIT. Otherwise go to REQ. In both cases valid <= 0.
- Redirect has priority over everything, including stall_f, in every state except IDLE:
  - pc_q <= redirect_pc and valid <= 0.
  - In WAIT without a response this cycle: kill <= 1 and stay in WAIT.
  - In WAIT with a response this cycle: drop it and go to REQ.
  - In REQ or FULL: go to REQ.
  - A second redirect while kill=1 only updates pc_q.
- Requests may be withdrawn (valid deasserted without ready) only on redirect. Otherwise valid and addr are held until ready.
- At most one outstanding request. Exactly one response per accepted request, arriving at least 1 cycle after acceptance. imem_rsp_valid outside WAIT is illegal (assertion).
- Output mux: instr_f = valid ? buffer.instr : NOP_INSTR. pc_f = buffer.pc. pc_plus4_f = buffer.pc + 4, 32-bit wrap.

## Timing
- Reset values: state IDLE, pc_q = RESET_PC, valid_f=0, instr_f=NOP_INSTR, pc_f=0, pc_plus4_f=4, kill=0, imem_req_valid=0, imem_req_addr=RESET_PC.
- Zero-wait memory (ready=1, response 1 cycle later) gives a steady state of 1 instruction per 2 cycles (FULL→WAIT→FULL).
- First instruction: request in cycle 1 after reset release, response in cycle 2, valid_f=1 in cycle 3.
- All outputs are registered-state functions except imem_req_valid, which is combinational from state, stall_f and redirect.
- rst asserted mid-transaction returns to IDLE immediately. A late response after reset is ignored because the state is not WAIT.

## Structure
- fetch_pkg: state enum (IDLE, REQ, WAIT, FULL), NOP_INSTR constant, default RESET_PC.
- Single module, no sub-module. The output buffer and FSM are small enough to stay inline.

## Test plan
- Reset, RESET_PC=0x100, zero-wait memory returning addr^0xA5A5_0000 -> valid_f first high with pc_f=0x100, pc_plus4_f=0x104, then pc_f 0x104, 0x108 every 2 cycles.
- stall_f held 3 cycles while FULL at pc 0x108 -> outputs frozen, no imem_req_valid. On release, the request for 0x10C is issued the same cycle.
- redirect to 0x200 while WAIT for 0x110, response arrives 2 cycles later -> response dropped, next request addr=0x200, next valid pc_f=0x200.
- redirect to 0x300 in the same cycle as imem_rsp_valid in WAIT -> data dropped, state REQ, next addr 0x300.
- imem_req_ready low 4 cycles in REQ -> addr stable at pc_q, no state change. Redirect to 0x400 during the stall -> request withdrawn, next addr 0x400.
- pc_q=0xFFFF_FFFC fetched -> pc_plus4_f=0x0000_0000, next request addr 0x0.
